// File: rtl/fft_seq_pkg.sv
// fft_seq_pkg: shared states, error bit positions and default sizes for the FFT frame sequencer.
package fft_seq_pkg;
    localparam int WIDTH_DEF         = 9;
    localparam int LANES_DEF         = 16;
    localparam int BEATS_DEF         = 32;
    localparam int DRAIN_TIMEOUT_DEF = 64;
    localparam int ERR_UNDERFLOW     = 0;
    localparam int ERR_LENGTH        = 1;
    localparam int ERR_TIMEOUT       = 2;
    typedef enum logic [1:0] {IDLE, FILL, DRAIN, DONE} state_e;
    typedef logic signed [WIDTH_DEF-1:0] sample_t;
    typedef sample_t [LANES_DEF-1:0] lane_vec_t;
endpackage

// File: rtl/fft_seq_beat_reg.sv
// fft_seq_beat_reg: registered multi-lane I/Q capture; loads zeros whenever no beat is taken.
module fft_seq_beat_reg #(
    parameter int LANES = 16,
    parameter int WIDTH = 9
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                ld_i,
    input  logic signed [LANES-1:0][WIDTH-1:0] i_i,
    input  logic signed [LANES-1:0][WIDTH-1:0] q_i,
    output logic signed [LANES-1:0][WIDTH-1:0] i_o,
    output logic signed [LANES-1:0][WIDTH-1:0] q_o
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_o <= '0;
            q_o <= '0;
        end else begin
            i_o <= ld_i ? i_i : '0;
            q_o <= ld_i ? q_i : '0;
        end
    end
endmodule

// File: rtl/fft_frame_seq.sv
// fft_frame_seq: packages a valid/ready sample stream into fixed-length frames for the stage-0
// butterfly, counts returned output beats and reports per-frame errors.
module fft_frame_seq
    import fft_seq_pkg::*;
#(
    parameter int WIDTH         = WIDTH_DEF,
    parameter int LANES         = LANES_DEF,
    parameter int BEATS         = BEATS_DEF,
    parameter int DRAIN_TIMEOUT = DRAIN_TIMEOUT_DEF
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                enable,
    input  logic                                s_valid,
    output logic                                s_ready,
    input  logic                                s_last,
    input  logic signed [LANES-1:0][WIDTH-1:0] s_i,
    input  logic signed [LANES-1:0][WIDTH-1:0] s_q,
    output logic signed [LANES-1:0][WIDTH-1:0] in_i,
    output logic signed [LANES-1:0][WIDTH-1:0] in_q,
    output logic                                din_valid,
    input  logic                                shift_01_valid,
    output logic                                busy,
    output logic                                frame_done,
    output logic [2:0]                          frame_err,
    output logic [15:0]                         frame_cnt
);
    localparam int BW = $clog2(BEATS);
    localparam int OW = $clog2(BEATS + 1);
    localparam int TW = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
    localparam logic [OW-1:0] ALL_OUT   = OW'(BEATS);
    localparam logic [TW-1:0] TMO_LAST  = TW'(DRAIN_TIMEOUT - 1);
    state_e        state_q, state_d;
    logic [BW-1:0] beat_q, beat_d;
    logic [OW-1:0] out_q, out_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [2:0]    err_q, err_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d;
    logic          dv_q, rdy_q, busy_q, done_q;
    logic          fill, out_full;
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        tmr_d       = tmr_q;
        err_d       = err_q;
        frame_cnt_d = frame_cnt_q;
        fill        = state_q == FILL;
        out_full    = out_q == ALL_OUT;
        out_d       = (state_q != IDLE && shift_01_valid && !out_full) ? out_q + 1'b1 : out_q;
        case (state_q)
            IDLE: if (enable && s_valid) begin
                state_d = FILL;
                err_d   = '0;
                beat_d  = '0;
                out_d   = '0;
            end
            FILL: begin
                beat_d = beat_q + 1'b1;
                if (!s_valid) err_d[ERR_UNDERFLOW] = 1'b1;
                // s_last must coincide exactly with the final beat of the frame
                if (s_valid && (s_last != (beat_q == LAST_BEAT))) err_d[ERR_LENGTH] = 1'b1;
                if (beat_q == LAST_BEAT) begin
                    state_d = DRAIN;
                    tmr_d   = '0;
                end
            end
            DRAIN: begin
                tmr_d = tmr_q + 1'b1;
                if (out_full || tmr_q == TMO_LAST) begin
                    state_d            = DONE;
                    frame_cnt_d        = frame_cnt_q + 1'b1;
                    err_d[ERR_TIMEOUT] = !out_full;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            out_q       <= '0;
            tmr_q       <= '0;
            err_q       <= '0;
            frame_cnt_q <= '0;
            dv_q        <= 1'b0;
            rdy_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            out_q       <= out_d;
            tmr_q       <= tmr_d;
            err_q       <= err_d;
            frame_cnt_q <= frame_cnt_d;
            dv_q        <= fill;
            rdy_q       <= state_d == FILL;
            busy_q      <= state_d != IDLE;
            done_q      <= state_d == DONE;
        end
    end
    fft_seq_beat_reg #(.LANES(LANES), .WIDTH(WIDTH)) u_beat (
        .clk (clk),
        .rst (rst),
        .ld_i(fill && s_valid),
        .i_i (s_i),
        .q_i (s_q),
        .i_o (in_i),
        .q_o (in_q)
    );
    assign s_ready    = rdy_q;
    assign din_valid  = dv_q;
    assign busy       = busy_q;
    assign frame_done = done_q;
    assign frame_err  = err_q;
    assign frame_cnt  = frame_cnt_q;
endmodule

// File: tb/tb_fft_frame_seq.sv
// tb_fft_frame_seq: directed frame scenarios with a delayed-return model of the butterfly output.
module tb_fft_frame_seq;
    import fft_seq_pkg::*;
    logic clk, rst, enable, s_valid, s_ready, s_last, din_valid, shift_01_valid, busy, frame_done;
    lane_vec_t s_i, s_q, in_i, in_q;
    logic [2:0] frame_err;
    logic [15:0] frame_cnt;
    int nvec = 0, nfail = 0, cyc = 0;
    int dv_total, max_run, data_bad, done_n, t_done, first_rdy, first_dv, last_dv, drain_t;
    logic [2:0] err_done, err_fill;
    logic [15:0] cnt_done;

    fft_frame_seq dut (
        .clk(clk), .rst(rst), .enable(enable), .s_valid(s_valid), .s_ready(s_ready),
        .s_last(s_last), .s_i(s_i), .s_q(s_q), .in_i(in_i), .in_q(in_q),
        .din_valid(din_valid), .shift_01_valid(shift_01_valid), .busy(busy),
        .frame_done(frame_done), .frame_err(frame_err), .frame_cnt(frame_cnt)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    function automatic logic [8:0] pat(int b, int l, int s);
        logic [7:0] v;
        v = 8'(b * 17 + l * 5 + s * 31);
        return {1'b1, v};
    endfunction

    task automatic drive_beat(input int b, input int seed);
        for (int l = 0; l < 16; l++) begin
            s_i[l] = pat(b, l, seed);
            s_q[l] = pat(b, l, seed) ^ 9'h0AA;
        end
    endtask

    // Drives one frame and records what the DUT did; the test tasks judge the record.
    task automatic run_frame(input int seed, input int drop_lo, input int drop_hi,
                             input int last_beat, input int n_ret, input bit keep);
        bit started = 0, prev_rdy = 0, drop;
        int slot = 0, oslot = 0, nret = 0, run = 0;
        logic [2:0] dvh = '0;
        logic [8:0] ei, eq;
        dv_total = 0; max_run = 0; data_bad = 0; done_n = 0;
        t_done = -1; first_rdy = -1; first_dv = -1; last_dv = -1; drain_t = -1;
        err_done = 'x; err_fill = 'x; cnt_done = 'x;
        for (int c = 0; c < 400; c++) begin
            if (s_ready) begin
                started = 1;
                s_valid = !(slot >= drop_lo && slot <= drop_hi);
                s_last  = slot == last_beat;
                drive_beat(slot, seed);
                slot++;
            end else begin
                s_valid = keep || !started;
                s_last  = 0;
                drive_beat(0, seed);
            end
            enable = keep || !started;
            shift_01_valid = dvh[2] && nret < n_ret;
            if (shift_01_valid) nret++;
            @(posedge clk); #1; cyc++;
            dvh = {dvh[1:0], din_valid};
            if (din_valid) begin
                dv_total++;
                run++;
                if (run > max_run) max_run = run;
                drop = oslot >= drop_lo && oslot <= drop_hi;
                for (int l = 0; l < 16; l++) begin
                    ei = drop ? 9'h0 : pat(oslot, l, seed);
                    eq = drop ? 9'h0 : pat(oslot, l, seed) ^ 9'h0AA;
                    if (in_i[l] !== ei || in_q[l] !== eq) data_bad++;
                end
                oslot++;
                if (first_dv < 0) first_dv = cyc;
                last_dv = cyc;
            end else run = 0;
            if (s_ready && first_rdy < 0) begin first_rdy = cyc; err_fill = frame_err; end
            if (prev_rdy && !s_ready && drain_t < 0) drain_t = cyc;
            prev_rdy = s_ready;
            if (frame_done) begin
                done_n++;
                if (t_done < 0) begin t_done = cyc; err_done = frame_err; cnt_done = frame_cnt; end
            end
            if (t_done >= 0 && cyc > t_done) break;
        end
        shift_01_valid = 0;
        if (t_done < 0) begin
            nvec++; nfail++;
            $display("FAIL frame_timeout: no frame_done within 400 cycles, required one");
        end
    endtask

    task automatic test_reset;
        #1;
        nvec++; if (din_valid !== 1'b0) begin nfail++; $display("FAIL rst_din_valid: got %b required 0", din_valid); end
        nvec++; if (s_ready !== 1'b0) begin nfail++; $display("FAIL rst_s_ready: got %b required 0", s_ready); end
        nvec++; if (busy !== 1'b0 || frame_done !== 1'b0) begin nfail++; $display("FAIL rst_busy_done: got %b%b required 00", busy, frame_done); end
        nvec++; if (frame_err !== 3'b000) begin nfail++; $display("FAIL rst_frame_err: got %b required 000", frame_err); end
        nvec++; if (frame_cnt !== 16'h0) begin nfail++; $display("FAIL rst_frame_cnt: got %h required 0000", frame_cnt); end
        nvec++; if (in_i !== '0 || in_q !== '0) begin nfail++; $display("FAIL rst_data: got nonzero in_i/in_q required 0"); end
        repeat (2) @(posedge clk);
        #1 rst = 0;
    endtask

    task automatic test_nominal;
        run_frame(1, -1, -2, 31, 32, 0);
        nvec++; if (max_run !== 32 || dv_total !== 32) begin nfail++; $display("FAIL nom_din_valid: got run %0d total %0d required 32 32", max_run, dv_total); end
        nvec++; if (data_bad !== 0) begin nfail++; $display("FAIL nom_data: got %0d bad lanes required 0", data_bad); end
        nvec++; if (done_n !== 1) begin nfail++; $display("FAIL nom_done_pulse: got %0d pulses required 1", done_n); end
        nvec++; if (err_done !== 3'b000) begin nfail++; $display("FAIL nom_err: got %b required 000", err_done); end
        nvec++; if (cnt_done !== 16'd1) begin nfail++; $display("FAIL nom_cnt: got %0d required 1", cnt_done); end
        nvec++; if (first_dv - first_rdy !== 1) begin nfail++; $display("FAIL nom_latency: got %0d required 1", first_dv - first_rdy); end
    endtask

    task automatic test_underflow;
        run_frame(2, 10, 12, 31, 32, 0);
        nvec++; if (max_run !== 32 || dv_total !== 32) begin nfail++; $display("FAIL unf_din_valid: got run %0d total %0d required 32 32", max_run, dv_total); end
        nvec++; if (data_bad !== 0) begin nfail++; $display("FAIL unf_data: got %0d bad lanes required 0", data_bad); end
        nvec++; if (err_done !== 3'b001) begin nfail++; $display("FAIL unf_err: got %b required 001", err_done); end
        nvec++; if (cnt_done !== 16'd2) begin nfail++; $display("FAIL unf_cnt: got %0d required 2", cnt_done); end
    endtask

    task automatic test_length;
        run_frame(3, -1, -2, 20, 32, 0);
        nvec++; if (dv_total !== 32 || data_bad !== 0) begin nfail++; $display("FAIL len_early_frame: got total %0d bad %0d required 32 0", dv_total, data_bad); end
        nvec++; if (err_done !== 3'b010) begin nfail++; $display("FAIL len_early_err: got %b required 010", err_done); end
        run_frame(4, -1, -2, -1, 32, 0);
        nvec++; if (err_done !== 3'b010) begin nfail++; $display("FAIL len_missing_err: got %b required 010", err_done); end
        nvec++; if (cnt_done !== 16'd4) begin nfail++; $display("FAIL len_cnt: got %0d required 4", cnt_done); end
    endtask

    task automatic test_timeout;
        run_frame(5, -1, -2, 31, 30, 0);
        nvec++; if (t_done - drain_t !== 64) begin nfail++; $display("FAIL tmo_delay: got %0d cycles required 64", t_done - drain_t); end
        nvec++; if (err_done !== 3'b100) begin nfail++; $display("FAIL tmo_err: got %b required 100", err_done); end
        nvec++; if (frame_err !== 3'b100) begin nfail++; $display("FAIL tmo_sticky: got %b required 100", frame_err); end
        run_frame(6, -1, -2, 31, 32, 0);
        nvec++; if (err_fill !== 3'b000) begin nfail++; $display("FAIL tmo_clear_on_fill: got %b required 000", err_fill); end
        nvec++; if (err_done !== 3'b000 || cnt_done !== 16'd6) begin nfail++; $display("FAIL tmo_next_frame: got err %b cnt %0d required 000 6", err_done, cnt_done); end
    endtask

    task automatic test_reset_mid_fill;
        int n = 0;
        enable = 1; s_valid = 1; drive_beat(0, 7);
        for (int c = 0; c < 40 && n < 16; c++) begin
            @(posedge clk); #1; cyc++;
            if (s_ready) n++;
        end
        nvec++; if (din_valid !== 1'b1 || busy !== 1'b1) begin nfail++; $display("FAIL mid_in_frame: got dv %b busy %b required 1 1", din_valid, busy); end
        #3 rst = 1;
        #1;
        nvec++; if (din_valid !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b0) begin nfail++; $display("FAIL mid_async_clear: got dv %b busy %b rdy %b required 0 0 0", din_valid, busy, s_ready); end
        nvec++; if (frame_cnt !== 16'h0) begin nfail++; $display("FAIL mid_cnt_clear: got %0d required 0", frame_cnt); end
        s_valid = 0; enable = 0;
        @(posedge clk); #1; cyc++;
        rst = 0;
        run_frame(8, -1, -2, 31, 32, 0);
        nvec++; if (dv_total !== 32 || data_bad !== 0 || err_done !== 3'b000) begin nfail++; $display("FAIL mid_fresh_frame: got total %0d bad %0d err %b required 32 0 000", dv_total, data_bad, err_done); end
        nvec++; if (cnt_done !== 16'd1) begin nfail++; $display("FAIL mid_cnt_restart: got %0d required 1", cnt_done); end
    endtask

    task automatic test_back_to_back;
        int prev_done = -1, prev_last = -1;
        rst = 1;
        @(posedge clk); #1; cyc++;
        rst = 0;
        for (int k = 0; k < 3; k++) begin
            run_frame(10 + k, -1, -2, 31, 32, 1);
            nvec++; if (dv_total !== 32 || max_run !== 32 || data_bad !== 0) begin nfail++; $display("FAIL b2b_frame%0d: got total %0d run %0d bad %0d required 32 32 0", k, dv_total, max_run, data_bad); end
            nvec++; if (cnt_done !== 16'(k + 1)) begin nfail++; $display("FAIL b2b_cnt%0d: got %0d required %0d", k, cnt_done, k + 1); end
            if (k > 0) begin
                nvec++; if (first_rdy - prev_done !== 2) begin nfail++; $display("FAIL b2b_gap%0d: got %0d required 2", k, first_rdy - prev_done); end
                nvec++; if (!(first_dv > prev_last + 1)) begin nfail++; $display("FAIL b2b_overlap%0d: got first %0d prev last %0d required separated", k, first_dv, prev_last); end
            end
            prev_done = t_done;
            prev_last = last_dv;
        end
        s_valid = 0; enable = 0;
    endtask

    task automatic test_wrap;
        force dut.frame_cnt_q = 16'hFFFF;
        @(posedge clk); #1; cyc++;
        release dut.frame_cnt_q;
        nvec++; if (frame_cnt !== 16'hFFFF) begin nfail++; $display("FAIL wrap_preload: got %h required ffff", frame_cnt); end
        run_frame(20, -1, -2, 31, 32, 0);
        nvec++; if (cnt_done !== 16'h0000) begin nfail++; $display("FAIL wrap_cnt: got %h required 0000", cnt_done); end
    endtask

    initial begin
        rst = 1; enable = 0; s_valid = 0; s_last = 0; shift_01_valid = 0;
        s_i = '0; s_q = '0;
        test_reset;
        test_nominal;
        test_underflow;
        test_length;
        test_timeout;
        test_reset_mid_fill;
        test_back_to_back;
        test_wrap;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule

// File: doc/fft_frame_seq.md
Name: fft_frame_seq

Overview:
- Input-side sequencer for the stage-0 FFT butterfly (module_00).
- Takes a 16-lane I/Q sample stream over a valid/ready handshake and packages it into 32-beat frames (512 points). Drives module_00 with an unbroken 32-cycle din_valid burst per frame.
- Counts the 32 returned shift_01_valid beats, flags frame errors and gates the next frame.
- Sits between the sample source (ADC/capture FIFO) and module_00; one frame in flight at a time.

Parameters:
- WIDTH, 9, sample width per I/Q component (matches module_00 WIDTH).
- LANES, 16, samples per beat.
- BEATS, 32, beats per frame.
- DRAIN_TIMEOUT, 64, max cycles in DRAIN waiting for remaining output beats.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  allow new frames to start; sampled only in IDLE.
- s_valid  in  1  source beat valid.
- s_ready  out  1  sequencer accepts beat.
- s_last  in  1  source marks final beat of frame.
- s_i  in  LANES x WIDTH signed  source I samples.
- s_q  in  LANES x WIDTH signed  source Q samples.
- in_i  out  LANES x WIDTH signed  to module_00 in_i.
- in_q  out  LANES x WIDTH signed  to module_00 in_q.
- din_valid  out  1  to module_00 din_valid.
- shift_01_valid  in  1  module_00 output-valid.
- busy  out  1  frame in progress (state != IDLE).
- frame_done  out  1  one-cycle pulse at frame completion.
- frame_err  out  3  sticky flags {timeout, length, underflow}; cleared at next frame start.
- frame_cnt  out  16  completed frames, wraps at 0xFFFF.

Behaviour:
- Reset (async, rst=1): state IDLE, din_valid=0, in_i/in_q=0, s_ready=0, busy=0, frame_done=0, frame_err=0, frame_cnt=0, beat/out counters=0. Takes effect immediately, including mid-frame: din_valid drops without waiting for a clock edge.
- All outputs are registered. Data path latency is 1 cycle: a beat accepted at edge N appears on in_i/in_q with din_valid=1 after edge N.
- IDLE:
  - s_ready=0.
  - If enable && s_valid: go to FILL on the next edge. frame_err clears to 0, beat_cnt=0, out_cnt=0.
  - That first beat is not consumed in IDLE.
- FILL:
  - s_ready=1 for exactly BEATS cycles.
  - Every FILL cycle registers one beat and drives din_valid=1, so din_valid is contiguous for 32 cycles.
  - If s_valid=0 in a FILL cycle: register zeros (pad) and set frame_err[0] (underflow). Padding continues the frame; alignment is never lost.
  - s_last=1 while beat_cnt<BEATS-1: set frame_err[1] (length). Remaining beats are still taken from the stream.
  - s_last=0 on beat BEATS-1 with s_valid=1: set frame_err[1].
  - After beat BEATS-1: go to DRAIN.
- out_cnt:
  - Increments on every shift_01_valid=1 while busy, including during FILL (module_00 output may overlap input).
  - Saturates at BEATS.
- DRAIN:
  - s_ready=0, din_valid=0.
  - Leave when out_cnt==BEATS, or when the drain timer reaches DRAIN_TIMEOUT. On timeout, set frame_err[2].
  - Next state is DONE.
- DONE (1 cycle): frame_done=1, frame_cnt+=1, then return to IDLE.
  - A new frame may begin FILL at the earliest 1 cycle after frame_done (IDLE must sample s_valid).
- shift_01_valid while IDLE: ignored, no counter change.
- enable deasserted mid-frame: no effect; the current frame completes.

Decomposition:
- Package fft_seq_pkg:
  - state enum {IDLE, FILL, DRAIN, DONE};
  - frame_err bit index constants ERR_UNDERFLOW=0, ERR_LENGTH=1, ERR_TIMEOUT=2;
  - typedef for the LANES x WIDTH signed sample array;
  - default BEATS/LANES constants.
- One natural sub-module: fft_seq_beat_reg. It is the registered 16-lane I/Q capture with pad-to-zero select and async clear, instantiated for the data path. FSM and counters stay in the top.

Test Plan:
- Nominal frame: enable=1, source supplies 32 beats with s_last on beat 31, model returns 32 shift_01_valid starting 2 cycles after first din_valid -> din_valid high exactly 32 consecutive cycles, in_i/in_q equal to inputs delayed 1 cycle, frame_done single pulse, frame_err=3'b000, frame_cnt=1.
- Underflow: drop s_valid on beats 10..12 -> in_i/in_q=0 on those 3 beats, din_valid still 32 contiguous cycles, frame_err=3'b001 at frame_done.
- Length error: s_last on beat 20 -> frame still 32 beats, frame_err=3'b010. Separately, no s_last on beat 31 -> frame_err=3'b010.
- Drain timeout: model returns only 30 shift_01_valid beats -> frame_done at DRAIN entry + 64 cycles, frame_err=3'b100. The next frame clears frame_err to 0 on FILL entry.
- Reset mid-FILL: assert rst at beat 15 -> din_valid, busy, s_ready go 0 immediately. After rst release with enable=1, s_valid=1, a full fresh 32-beat frame runs; frame_cnt restarts from 0.
- Back-to-back and wrap: 3 frames with s_valid always 1 -> frames separated by DONE+IDLE cycles, no overlap of din_valid bursts, frame_cnt=3. Preload frame_cnt to 0xFFFF via force, then one more frame -> 0x0000.
